// File: rtl/buffer_bias_pp.sv
// buffer_bias_pp: ping-pong per-channel bias store with round-robin serial load and parallel read.
// Define BIAS_BUF_OUT_REG_EN to add an output register (read latency 2 instead of 1).
module buffer_bias_pp #(
  parameter int NUM_CH   = 8,
  parameter int WIDTH    = 18,
  parameter int DEPTH    = 128,
  parameter int ADDR_BIT = 7,
  parameter     RAM_STYLE_VAL = "block"
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      start,
  input  logic [ADDR_BIT:0]         load_len,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  output logic                      load_done,
  input  logic                      swap,
  output logic                      swap_ack,
  input  logic                      rd_en,
  input  logic [ADDR_BIT-1:0]       rd_addr,
  output logic                      rd_valid,
  output logic [NUM_CH*WIDTH-1:0]   rd_data
);
  localparam int CW = $clog2(NUM_CH);
  localparam logic [ADDR_BIT:0] DEPTH_L = (ADDR_BIT+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_n;
  logic wr_bank, bank_n;
  logic [CW-1:0] ch_ptr, ptr_n;
  logic [ADDR_BIT-1:0] wr_addr, addr_n;
  logic [ADDR_BIT:0] len, len_n, len_in;
  logic swap_take, start_take, acc, last, rd_v1;
  logic [NUM_CH*WIDTH-1:0] raw;
  assign len_in     = (load_len > DEPTH_L) ? DEPTH_L : load_len;
  assign swap_take  = !clear && swap && state != LOAD;
  assign start_take = !clear && !swap_take && start && state != LOAD;
  assign acc        = !clear && state == LOAD && in_valid;
  assign last       = acc && ch_ptr == CW'(NUM_CH-1) && {1'b0, wr_addr} == len - 1'b1;
  assign in_ready   = state == LOAD;
  assign load_done  = state == DONE;
  always_comb begin
    state_n = state;
    bank_n  = wr_bank;
    ptr_n   = ch_ptr;
    addr_n  = wr_addr;
    len_n   = len;
    if (clear || swap_take || start_take) begin
      ptr_n  = '0;
      addr_n = '0;
      state_n = IDLE;
      bank_n  = swap_take ? ~wr_bank : wr_bank;
      if (start_take) begin
        len_n   = len_in;
        state_n = (len_in == '0) ? DONE : LOAD;
      end
    end else if (acc) begin
      ptr_n   = ch_ptr + 1'b1;
      addr_n  = (ch_ptr == CW'(NUM_CH-1)) ? wr_addr + 1'b1 : wr_addr;
      state_n = last ? DONE : LOAD;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_bank  <= 1'b0;
      ch_ptr   <= '0;
      wr_addr  <= '0;
      len      <= '0;
      swap_ack <= 1'b0;
      rd_v1    <= 1'b0;
    end else begin
      state    <= state_n;
      wr_bank  <= bank_n;
      ch_ptr   <= ptr_n;
      wr_addr  <= addr_n;
      len      <= len_n;
      swap_ack <= swap_take;
      rd_v1    <= rd_en;
    end
  end
  // Bank bit is the address MSB; reads always target the bank opposite the writer.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    (* ram_style = RAM_STYLE_VAL *) logic [WIDTH-1:0] mem [2**(ADDR_BIT+1)];
    logic [WIDTH-1:0] q;
    always_ff @(posedge clk) begin
      if (acc && ch_ptr == CW'(k)) mem[{wr_bank, wr_addr}] <= in_data;
      if (rd_en) q <= mem[{~wr_bank, rd_addr}];
    end
    assign raw[k*WIDTH +: WIDTH] = q;
  end
`ifdef BIAS_BUF_OUT_REG_EN
  logic rd_v2;
  logic [NUM_CH*WIDTH-1:0] rd_q2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v2 <= 1'b0;
      rd_q2 <= '0;
    end else begin
      rd_v2 <= rd_v1;
      rd_q2 <= rd_v1 ? raw : '0;
    end
  end
  assign rd_valid = rd_v2;
  assign rd_data  = rd_v2 ? rd_q2 : '0;
`else
  assign rd_valid = rd_v1;
  assign rd_data  = rd_v1 ? raw : '0;
`endif
endmodule
